// File: rtl/fancy_timer_datapath.sv
// Datapath for the sequence-detect/timer FSM: serially loads a delay, then counts
// (delay+1)*TICKS cycles and raises done_counting on the final cycle.
module fancy_timer_datapath #(
  parameter int  DELAY_W = 4,
  parameter int  TICKS   = 1000,
  localparam int TICK_W  = $clog2(TICKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d,
  input  logic               shift_ena,
  input  logic               counting,
  output logic               done_counting,
  output logic [DELAY_W-1:0] count,
  output logic [TICK_W-1:0]  tick,
  output logic               proto_err
);

  localparam int                SC_W      = $clog2(DELAY_W + 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
  localparam logic [SC_W-1:0]   SC_FULL   = SC_W'(DELAY_W);
  localparam logic [SC_W-1:0]   SC_MAX    = SC_W'(DELAY_W + 1);

  logic [DELAY_W-1:0] delay_q;
  logic [TICK_W-1:0]  tick_q;
  logic [SC_W-1:0]    shift_cnt;
  logic               counting_q;
  logic               proto_err_q;
  logic               tick_wrap;
  logic               count_start;

  assign tick_wrap   = (tick_q == TICK_LAST);
  assign count_start = counting & ~counting_q;

  // Shift has priority over counting; any cycle with neither restarts the tick phase
  // but keeps the remaining delay units so an aborted count can resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q     <= '0;
      tick_q      <= '0;
      shift_cnt   <= '0;
      counting_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      counting_q <= counting;
      if (shift_ena) begin
        delay_q <= (delay_q << 1) | DELAY_W'(d);
        tick_q  <= '0;
        if (shift_cnt != SC_MAX)
          shift_cnt <= shift_cnt + SC_W'(1);
      end else if (counting) begin
        if (tick_wrap) begin
          tick_q <= '0;
          if (delay_q != '0)
            delay_q <= delay_q - DELAY_W'(1);
        end else begin
          tick_q <= tick_q + TICK_W'(1);
        end
      end else begin
        tick_q <= '0;
      end
      if (count_start)
        shift_cnt <= '0;
      // A count must start after exactly DELAY_W shifts, and shift/count never overlap.
      if ((shift_ena && counting) || (count_start && (shift_cnt != SC_FULL)))
        proto_err_q <= 1'b1;
    end
  end

  assign done_counting = counting & ~shift_ena & tick_wrap & (delay_q == '0);
  assign count         = delay_q;
  assign tick          = tick_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_fancy_timer_datapath.sv
// Scoreboard bench: two DUTs (TICKS=1000 and TICKS=2) share one stimulus stream and
// are checked every cycle against an integer reference model, plus directed checks.
module tb_fancy_timer_datapath;

  localparam int DW = 4;
  localparam int T1 = 1000;
  localparam int T2 = 2;

  typedef struct {
    int delay;
    int phase;
    int nshift;
    bit cnt_prev;
    bit err;
  } model_t;

  typedef struct {
    bit done1;
    int count1;
    int tick1;
    bit err1;
    bit done2;
    int count2;
    int tick2;
    bit err2;
  } exp_t;

  logic clk, rst, d, shift_ena, counting;
  logic          done1, err1, done2, err2;
  logic [DW-1:0] count1, count2;
  logic [9:0]    tick1;
  logic [0:0]    tick2;

  int     compared = 0;
  int     mismatched = 0;
  bit     started = 0;
  bit     done1_s, done2_s;
  model_t m1, m2;
  exp_t   exp_q[$];
  exp_t   mon_e;

  fancy_timer_datapath #(.DELAY_W(DW), .TICKS(T1)) u_dut1 (
    .clk(clk), .rst(rst), .d(d), .shift_ena(shift_ena), .counting(counting),
    .done_counting(done1), .count(count1), .tick(tick1), .proto_err(err1)
  );

  fancy_timer_datapath #(.DELAY_W(DW), .TICKS(T2)) u_dut2 (
    .clk(clk), .rst(rst), .d(d), .shift_ena(shift_ena), .counting(counting),
    .done_counting(done2), .count(count2), .tick(tick2), .proto_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_done(input model_t m, input int ticks, input bit sh, input bit cn);
    return cn && !sh && (m.phase == ticks - 1) && (m.delay == 0);
  endfunction

  // Delay value in integer units, phase counts cycles within the current unit.
  function automatic model_t model_step(input model_t m, input int ticks, input bit r,
                                        input bit dd, input bit sh, input bit cn);
    model_t n;
    if (r) begin
      n = '{0, 0, 0, 1'b0, 1'b0};
      return n;
    end
    n = m;
    n.cnt_prev = cn;
    if (sh) begin
      n.delay  = (m.delay * 2 + int'(dd)) % (1 << DW);
      n.nshift = (m.nshift + 1 > DW + 1) ? DW + 1 : m.nshift + 1;
      n.phase  = 0;
      if (cn) n.err = 1'b1;
    end else if (cn) begin
      if (m.phase == ticks - 1) begin
        n.phase = 0;
        n.delay = (m.delay > 0) ? m.delay - 1 : 0;
      end else begin
        n.phase = m.phase + 1;
      end
    end else begin
      n.phase = 0;
    end
    if (cn && !m.cnt_prev) begin
      if (m.nshift != DW) n.err = 1'b1;
      n.nshift = 0;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit dd, input bit sh, input bit cn);
    exp_t e;
    rst = r; d = dd; shift_ena = sh; counting = cn;
    if (started) begin
      e.done1  = model_done(m1, T1, sh, cn);
      e.count1 = m1.delay;
      e.tick1  = m1.phase;
      e.err1   = m1.err;
      e.done2  = model_done(m2, T2, sh, cn);
      e.count2 = m2.delay;
      e.tick2  = m2.phase;
      e.err2   = m2.err;
      exp_q.push_back(e);
    end
    #3;
    done1_s = done1;
    done2_s = done2;
    @(posedge clk);
    m1 = model_step(m1, T1, r, dd, sh, cn);
    m2 = model_step(m2, T2, r, dd, sh, cn);
    started = 1'b1;
    #1;
  endtask

  task automatic shiftValue(input int v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--)
      applyStimulus(1'b0, bit'((v >> i) & 1), 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("done1", int'(done1), int'(mon_e.done1));
      checkOutput("count1", int'(count1), mon_e.count1);
      checkOutput("tick1", int'(tick1), mon_e.tick1);
      checkOutput("err1", int'(err1), int'(mon_e.err1));
      checkOutput("done2", int'(done2), int'(mon_e.done2));
      checkOutput("count2", int'(count2), mon_e.count2);
      checkOutput("tick2", int'(tick2), mon_e.tick2);
      checkOutput("err2", int'(err2), int'(mon_e.err2));
    end
  end

  initial begin
    int first;
    int mask;
    int len;
    rst = 1'b1; d = 1'b0; shift_ena = 1'b0; counting = 1'b0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("idle_count", int'(count1), 0);
    checkOutput("idle_tick", int'(tick1), 0);
    checkOutput("idle_done", int'(done1_s), 0);
    checkOutput("idle_err", int'(err1), 0);

    // Load 1101 = 13 and time the full interval.
    shiftValue(13, 4);
    checkOutput("count_after_shift", int'(count1), 13);
    first = 0;
    for (int k = 1; k <= 14000; k++) begin
      applyStimulus(0, 0, 0, 1);
      if (done1_s && first == 0) first = k;
      if (k == 1000) checkOutput("count_after_1000", int'(count1), 12);
    end
    checkOutput("first_done_d13", first, 14000);
    checkOutput("err_after_clean_run", int'(err1), 0);
    applyStimulus(0, 0, 0, 0);

    // Zero delay: one unit on DUT1, repeated overrun pulses on the TICKS=2 DUT.
    applyStimulus(1, 0, 0, 0);
    shiftValue(0, 4);
    first = 0;
    mask = 0;
    for (int k = 1; k <= 1000; k++) begin
      applyStimulus(0, 0, 0, 1);
      if (k <= 6 && done2_s) mask |= (1 << (k - 1));
      if (done1_s && first == 0) first = k;
      if (k == 6) checkOutput("count2_overrun", int'(count2), 0);
    end
    checkOutput("first_done_d0", first, 1000);
    checkOutput("done2_pulse_mask", mask, 42);
    applyStimulus(0, 0, 0, 0);

    // Short shift, then overlapping shift and count.
    applyStimulus(1, 0, 0, 0);
    shiftValue(5, 3);
    applyStimulus(0, 0, 0, 1);
    checkOutput("err_short_shift", int'(err1), 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("err_sticky", int'(err1), 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("err_cleared", int'(err1), 0);
    shiftValue(9, 4);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("tick_before_overlap", int'(tick1), 10);
    checkOutput("err_before_overlap", int'(err1), 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("done_during_overlap", int'(done1_s), 0);
    checkOutput("tick_after_overlap", int'(tick1), 0);
    checkOutput("err_after_overlap", int'(err1), 1);

    // Interrupted count resumes with the remaining units.
    applyStimulus(1, 0, 0, 0);
    shiftValue(5, 4);
    for (int i = 0; i < 1500; i++) applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("count_after_gap", int'(count1), 4);
    checkOutput("tick_after_gap", int'(tick1), 0);
    first = 0;
    for (int k = 1; k <= 5000; k++) begin
      applyStimulus(0, 0, 0, 1);
      if (done1_s && first == 0) first = k;
    end
    checkOutput("first_done_resume", first, 5000);

    // Reset in the middle of a count.
    applyStimulus(1, 0, 0, 0);
    shiftValue(7, 5);
    for (int i = 0; i < 400; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("count_mid", int'(count1), 7);
    checkOutput("tick_mid", int'(tick1), 400);
    checkOutput("err_mid", int'(err1), 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("count_rst", int'(count1), 0);
    checkOutput("tick_rst", int'(tick1), 0);
    checkOutput("err_rst", int'(err1), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("done_rst", int'(done1_s), 0);

    // Randomized episodes: loads of varying length, counts with occasional gaps and shifts.
    for (int ep = 0; ep < 20; ep++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1, 0, 0, 0);
      shiftValue(int'($urandom_range(0, 31)), int'($urandom_range(3, 5)));
      len = int'($urandom_range(1, 2500));
      for (int k = 0; k < len; k++)
        applyStimulus(0, bit'($urandom & 1), $urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) != 0);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) applyStimulus(0, 0, 0, 0);
    end
    for (int k = 0; k < 1500; k++)
      applyStimulus($urandom_range(0, 199) == 0, bit'($urandom & 1),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6);

    applyStimulus(0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
